// File: rtl/lfsr5b_checker.sv
// Tracks a 5-bit x^5+x^2+1 pattern generator: predicts each word from the previous one,
// locks after LOCK_N good predictions, then counts mispredictions and checks the seed spacing.
module lfsr5b_checker #(
  parameter int LOCK_N   = 4,
  parameter int UNLOCK_N = 3,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic [4:0]    din,
  input  logic          din_vld,
  output logic          lock,
  output logic          err_pulse,
  output logic [CW-1:0] err_cnt,
  output logic          period_err,
  output logic          zero_err
);

  localparam int         MW      = $clog2(LOCK_N + 1);
  localparam int         XW      = $clog2(UNLOCK_N + 1);
  localparam logic [5:0] PERIOD  = 6'd31;
  localparam logic [5:0] PER_MAX = 6'h3f;
  localparam logic [4:0] SEED    = 5'h1f;

  typedef enum logic [1:0] {IDLE, HUNT, LOCKED, LOST} state_t;

  state_t        state, state_nxt;
  logic [4:0]    prev, prev_nxt;
  logic [MW-1:0] match_cnt, match_cnt_nxt;
  logic [XW-1:0] miss_cnt, miss_cnt_nxt;
  logic [5:0]    per_cnt, per_cnt_nxt;
  logic          seed_seen, seed_seen_nxt;
  logic [CW-1:0] err_cnt_nxt;
  logic          err_pulse_nxt, period_err_nxt, zero_err_nxt;
  logic [4:0]    pred;
  logic          match;

  function automatic logic [4:0] nxt(input logic [4:0] w);
    return {w[3], w[2], w[1] ^ w[4], w[0], w[4]};
  endfunction

  assign pred  = nxt(prev);
  // The generator never legitimately emits zero, so a zero word is never a match.
  assign match = (din == pred) && (din != 5'd0);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    prev_nxt       = prev;
    match_cnt_nxt  = match_cnt;
    miss_cnt_nxt   = miss_cnt;
    per_cnt_nxt    = per_cnt;
    seed_seen_nxt  = seed_seen;
    err_cnt_nxt    = err_cnt;
    err_pulse_nxt  = 1'b0;
    period_err_nxt = 1'b0;
    zero_err_nxt   = zero_err;

    if (din_vld) begin
      prev_nxt = din;
      if (din == 5'd0) begin
        zero_err_nxt = 1'b1;
      end

      unique case (state)
        IDLE: begin
          state_nxt = HUNT;
        end

        // LOST behaves as HUNT for its first word; match_cnt is already clear.
        HUNT, LOST: begin
          state_nxt = HUNT;
          if (!match) begin
            match_cnt_nxt = '0;
          end else if (match_cnt == MW'(LOCK_N - 1)) begin
            state_nxt     = LOCKED;
            match_cnt_nxt = '0;
            miss_cnt_nxt  = '0;
            seed_seen_nxt = 1'b0;
          end else begin
            match_cnt_nxt = match_cnt + 1'b1;
          end
        end

        LOCKED: begin
          if (match) begin
            miss_cnt_nxt = '0;
          end else begin
            err_pulse_nxt = 1'b1;
            if (err_cnt != '1) begin
              err_cnt_nxt = err_cnt + 1'b1;
            end
            if (miss_cnt == XW'(UNLOCK_N - 1)) begin
              state_nxt     = LOST;
              miss_cnt_nxt  = '0;
              match_cnt_nxt = '0;
            end else begin
              miss_cnt_nxt = miss_cnt + 1'b1;
            end
          end

          // per_cnt holds words since the last seed; it saturates so a long gap can't alias to 31.
          if (din == SEED) begin
            if (seed_seen && (per_cnt != PERIOD)) begin
              period_err_nxt = 1'b1;
            end
            per_cnt_nxt   = 6'd1;
            seed_seen_nxt = 1'b1;
          end else if (per_cnt != PER_MAX) begin
            per_cnt_nxt = per_cnt + 1'b1;
          end
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      prev       <= '0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      per_cnt    <= '0;
      seed_seen  <= 1'b0;
      lock       <= 1'b0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
      period_err <= 1'b0;
      zero_err   <= 1'b0;
    end else begin
      prev       <= prev_nxt;
      match_cnt  <= match_cnt_nxt;
      miss_cnt   <= miss_cnt_nxt;
      per_cnt    <= per_cnt_nxt;
      seed_seen  <= seed_seen_nxt;
      lock       <= (state_nxt == LOCKED);
      err_pulse  <= err_pulse_nxt;
      err_cnt    <= err_cnt_nxt;
      period_err <= period_err_nxt;
      zero_err   <= zero_err_nxt;
    end
  end

endmodule

// File: tb/tb_lfsr5b_checker.sv
// Bench for lfsr5b_checker: a default instance plus a CW=2 / UNLOCK_N=8 instance, both tracked
// against a sequence-table model every cycle, with directed scenarios and literal expectations.
module tb_lfsr5b_checker;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [4:0] din;
  logic       din_vld;

  logic       lock, err_pulse, period_err, zero_err;
  logic [7:0] err_cnt;
  logic       lock2, err_pulse2, period_err2, zero_err2;
  logic [1:0] err_cnt2;

  lfsr5b_checker dut (
    .clk(clk), .rst_b(rst_b), .din(din), .din_vld(din_vld),
    .lock(lock), .err_pulse(err_pulse), .err_cnt(err_cnt),
    .period_err(period_err), .zero_err(zero_err)
  );

  lfsr5b_checker #(.CW(2), .UNLOCK_N(8)) dut2 (
    .clk(clk), .rst_b(rst_b), .din(din), .din_vld(din_vld),
    .lock(lock2), .err_pulse(err_pulse2), .err_cnt(err_cnt2),
    .period_err(period_err2), .zero_err(zero_err2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  // Reference sequence as powers of x modulo x^5+x^2+1.
  logic [4:0] ref_seq [31];

  function automatic logic [4:0] gstep(input logic [4:0] w);
    return {w[3:0], 1'b0} ^ (w[4] ? 5'b00101 : 5'b00000);
  endfunction

  function automatic logic [4:0] predict(input logic [4:0] w);
    for (int i = 0; i < 31; i++) begin
      if (ref_seq[i] == w) return ref_seq[(i + 1) % 31];
    end
    return 5'd0;
  endfunction

  // Model state per instance: [0] = dut, [1] = dut2.
  int         lock_n [2];
  int         unlock_n [2];
  int         cmax [2];
  bit         m_have [2];
  bit         m_locked [2];
  int         m_run [2];
  int         m_miss [2];
  int         m_errs [2];
  int         m_idx [2];
  int         m_last [2];
  logic [4:0] m_prev [2];
  bit         e_errp [2];
  bit         e_perr [2];
  bit         e_zero [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_have[k] = 0; m_locked[k] = 0; m_run[k] = 0; m_miss[k] = 0; m_errs[k] = 0;
      m_idx[k] = 0; m_last[k] = -1; m_prev[k] = 5'd0;
      e_errp[k] = 0; e_perr[k] = 0; e_zero[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    bit hit;
    e_errp[k] = 0;
    e_perr[k] = 0;
    if (!din_vld) return;
    if (din == 5'd0) e_zero[k] = 1;
    hit = (din != 5'd0) && (din == predict(m_prev[k]));
    if (!m_have[k]) begin
      m_have[k] = 1;
    end else if (m_locked[k]) begin
      m_idx[k]++;
      if (din == 5'h1f) begin
        if (m_last[k] >= 0 && (m_idx[k] - m_last[k]) != 31) e_perr[k] = 1;
        m_last[k] = m_idx[k];
      end
      if (hit) begin
        m_miss[k] = 0;
      end else begin
        e_errp[k] = 1;
        if (m_errs[k] < cmax[k]) m_errs[k]++;
        m_miss[k]++;
        if (m_miss[k] == unlock_n[k]) begin
          m_locked[k] = 0; m_run[k] = 0; m_miss[k] = 0;
        end
      end
    end else begin
      m_run[k] = hit ? m_run[k] + 1 : 0;
      if (m_run[k] == lock_n[k]) begin
        m_locked[k] = 1; m_run[k] = 0; m_last[k] = -1;
      end
    end
    m_prev[k] = din;
  endtask

  initial begin
    lock_n[0] = 4; unlock_n[0] = 3; cmax[0] = 255;
    lock_n[1] = 4; unlock_n[1] = 8; cmax[1] = 3;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_b);
      if (!rst_b) model_reset();
      else for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  int ep_cnt [2] = '{0, 0};
  int pe_cnt [2] = '{0, 0};

  initial begin
    forever begin
      @(negedge clk);
      check("lock/0",  int'(lock),       int'(m_locked[0]));
      check("errp/0",  int'(err_pulse),  int'(e_errp[0]));
      check("errc/0",  int'(err_cnt),    m_errs[0]);
      check("perr/0",  int'(period_err), int'(e_perr[0]));
      check("zero/0",  int'(zero_err),   int'(e_zero[0]));
      check("lock/1",  int'(lock2),      int'(m_locked[1]));
      check("errp/1",  int'(err_pulse2), int'(e_errp[1]));
      check("errc/1",  int'(err_cnt2),   m_errs[1]);
      check("perr/1",  int'(period_err2), int'(e_perr[1]));
      check("zero/1",  int'(zero_err2),  int'(e_zero[1]));
      ep_cnt[0] += int'(err_pulse);  pe_cnt[0] += int'(period_err);
      ep_cnt[1] += int'(err_pulse2); pe_cnt[1] += int'(period_err2);
    end
  end

  int g = 0;
  int e0 [2];
  int p0 [2];

  // Called at a negedge: drive the word, return at the next negedge when outputs reflect it.
  task automatic send(input logic [4:0] w, input logic v);
    din = w;
    din_vld = v;
    @(negedge clk);
  endtask

  task automatic send_good();
    send(ref_seq[g], 1'b1);
    g = (g + 1) % 31;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic mark();
    for (int k = 0; k < 2; k++) begin
      e0[k] = ep_cnt[k];
      p0[k] = pe_cnt[k];
    end
  endtask

  task automatic pulse_reset();
    #2 rst_b = 1'b0;
    din_vld = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    g = 0;
  endtask

  initial begin
    rst_b = 1'b0;
    din = 5'd0;
    din_vld = 1'b0;
    ref_seq[0] = 5'h1f;
    for (int i = 1; i < 31; i++) ref_seq[i] = gstep(ref_seq[i-1]);

    check("ref1", int'(ref_seq[1]), 27);
    check("ref2", int'(ref_seq[2]), 19);
    check("ref3", int'(ref_seq[3]), 3);
    check("ref4", int'(ref_seq[4]), 6);
    check("ref_wrap", int'(gstep(ref_seq[30])), 31);

    #12;
    check("rst_lock", int'(lock), 0);
    check("rst_errc", int'(err_cnt), 0);
    check("rst_perr", int'(period_err), 0);
    check("rst_zero", int'(zero_err), 0);
    @(negedge clk);
    rst_b = 1'b1;

    // Acquire lock from the seed
    repeat (4) send_good();
    settle();
    check("t1_lock_after4", int'(lock), 0);
    send_good();
    settle();
    check("t1_lock_after5", int'(lock), 1);
    check("t1_errc", int'(err_cnt), 0);

    // Two full periods uninterrupted
    mark();
    repeat (62) send_good();
    settle();
    check("t2_errp", ep_cnt[0] - e0[0], 0);
    check("t2_perr", pe_cnt[0] - p0[0], 0);
    check("t2_lock", int'(lock), 1);

    // One corrupted word costs two mispredictions
    repeat (5) send_good();
    mark();
    send(ref_seq[g] ^ 5'b00001, 1'b1);
    g = (g + 1) % 31;
    repeat (10) send_good();
    settle();
    check("t3_errp", ep_cnt[0] - e0[0], 2);
    check("t3_errc", int'(err_cnt), 2);
    check("t3_lock", int'(lock), 1);

    // Three wrong words drop lock, then relock
    mark();
    send(5'b01010, 1'b1);
    send(5'b01010, 1'b1);
    settle();
    check("t4_lock_after2", int'(lock), 1);
    send(5'b01010, 1'b1);
    settle();
    check("t4_lock_after3", int'(lock), 0);
    check("t4_errp", ep_cnt[0] - e0[0], 3);
    check("t4_errc", int'(err_cnt), 5);
    repeat (4) send_good();
    settle();
    check("t4_relock_after4", int'(lock), 0);
    send_good();
    settle();
    check("t4_relock_after5", int'(lock), 1);

    // Saturation on the CW=2 instance
    pulse_reset();
    repeat (5) send_good();
    settle();
    check("t5_lock", int'(lock), 1);
    check("t5_lock2", int'(lock2), 1);
    for (int i = 0; i < 5; i++) send((i % 2 == 0) ? 5'b01010 : 5'b10101, 1'b1);
    settle();
    check("t5_errc2_sat", int'(err_cnt2), 3);
    check("t5_lock2_held", int'(lock2), 1);
    check("t5_lock_lost", int'(lock), 0);
    check("t5_errc", int'(err_cnt), 3);

    // Valid gaps inside a correct stream
    repeat (6) begin
      send_good();
      send(5'd0, 1'b0);
    end
    mark();
    for (int i = 0; i < 70; i++) begin
      send_good();
      if (i % 3 == 0) send(5'd0, 1'b0);
    end
    settle();
    check("t5_gap_errp", ep_cnt[0] - e0[0], 0);
    check("t5_gap_perr", pe_cnt[0] - p0[0], 0);
    check("t5_gap_errp2", ep_cnt[1] - e0[1], 0);
    check("t5_gap_perr2", pe_cnt[1] - p0[1], 0);
    check("t5_gap_lock", int'(lock), 1);
    check("t5_gap_zero", int'(zero_err), 0);

    // Zero word is sticky until reset; async reset clears everything
    send(5'd0, 1'b1);
    settle();
    check("t6_zero", int'(zero_err), 1);
    repeat (3) send_good();
    settle();
    check("t6_zero_sticky", int'(zero_err), 1);
    check("t6_zero_sticky2", int'(zero_err2), 1);
    din = ref_seq[g];
    din_vld = 1'b1;
    #2 rst_b = 1'b0;
    #1;
    check("t6_rst_lock", int'(lock), 0);
    check("t6_rst_errp", int'(err_pulse), 0);
    check("t6_rst_errc", int'(err_cnt), 0);
    check("t6_rst_perr", int'(period_err), 0);
    check("t6_rst_zero", int'(zero_err), 0);
    check("t6_rst_errc2", int'(err_cnt2), 0);
    din_vld = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    g = 0;
    repeat (4) send_good();
    settle();
    check("t6_relock_after4", int'(lock), 0);
    send_good();
    settle();
    check("t6_relock_after5", int'(lock), 1);

    // Out-of-place seed after a real one gives a period error
    repeat (31) send_good();
    mark();
    send(5'h1f, 1'b1);
    repeat (5) send_good();
    settle();
    check("t7_perr", pe_cnt[0] - p0[0], 1);
    check("t7_errp", ep_cnt[0] - e0[0], 2);
    check("t7_lock", int'(lock), 1);

    din_vld = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
